// File: rtl/phase_cycle_ctrl.sv
// Phase-cycled acquisition sequencer: counts scans, rotates the phase index
// through the latched cycle length, and reports completion or rejected starts.
module phase_cycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        scan_end,
    input  logic [1:0]  n_phases,
    input  logic [15:0] n_scans,
    output logic [1:0]  phase_sel,
    output logic [15:0] scan_count,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  cfg_phases, cfg_phases_nx;
    logic [15:0] cfg_scans, cfg_scans_nx;
    logic [1:0]  phase_nx;
    logic [15:0] count_nx;
    logic        busy_nx, done_nx, err_nx;
    logic [1:0]  phase_inc;
    logic [15:0] count_inc;

    assign phase_inc = phase_sel + 2'd1;
    assign count_inc = scan_count + 16'd1;

    // Every output is the registered copy of its *_nx value, so no input
    // reaches an output without passing through a flop.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // through the logic leaves it unassigned, which would infer a latch.
        state_nx      = state;
        cfg_phases_nx = cfg_phases;
        cfg_scans_nx  = cfg_scans;
        phase_nx      = phase_sel;
        count_nx      = scan_count;
        busy_nx       = busy;
        done_nx       = 1'b0;
        err_nx        = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (n_phases != 2'd0 && n_scans != 16'd0) begin
                        cfg_phases_nx = n_phases;
                        cfg_scans_nx  = n_scans;
                        phase_nx      = 2'd0;
                        count_nx      = 16'd0;
                        busy_nx       = 1'b1;
                        state_nx      = RUN;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    phase_nx = 2'd0;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else if (scan_end) begin
                    count_nx = count_inc;
                    if (count_inc == cfg_scans) begin
                        phase_nx = 2'd0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        phase_nx = (phase_inc == cfg_phases) ? 2'd0 : phase_inc;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                phase_nx = 2'd0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cfg_phases <= 2'd0;
            cfg_scans  <= 16'd0;
            phase_sel  <= 2'd0;
            scan_count <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            cfg_phases <= cfg_phases_nx;
            cfg_scans  <= cfg_scans_nx;
            phase_sel  <= phase_nx;
            scan_count <= count_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            cfg_err    <= err_nx;
        end
    end

endmodule

// File: doc/phase_cycle_ctrl.md
PHASE_CYCLE_CTRL -- requirements
Module: phase_cycle_ctrl

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit: the single system clock; all logic is clocked on the rising edge.
REQ-002 The block SHALL provide port rst_n, input, 1 bit: synchronous active-low reset, sampled on the clk rising edge.
REQ-003 The block SHALL provide port start, input, 1 bit: single-cycle request to begin a phase-cycled acquisition.
REQ-004 The block SHALL provide port abort, input, 1 bit: single-cycle request to terminate an acquisition immediately.
REQ-005 The block SHALL provide port scan_end, input, 1 bit: single-cycle pulse marking completion of one scan.
REQ-006 The block SHALL provide port n_phases, input, 2 bits: phase-cycle length; legal values are 1 to 3.
REQ-007 The block SHALL provide port n_scans, input, 16 bits: total scans per acquisition; legal values are 1 to 65535.
REQ-008 The block SHALL provide port phase_sel, output, 2 bits: registered phase index that drives the downstream phase selector.
REQ-009 The block SHALL provide port scan_count, output, 16 bits: number of scans completed in the current or last acquisition.
REQ-010 The block SHALL provide port busy, output, 1 bit: high while an acquisition is running.
REQ-011 The block SHALL provide port done, output, 1 bit: single-cycle pulse on normal completion.
REQ-012 The block SHALL provide port cfg_err, output, 1 bit: single-cycle pulse when a start is rejected.

Function
REQ-013 The block SHALL implement exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 with n_phases in 1..3 and n_scans nonzero SHALL cause the following on the next edge: latch n_phases and n_scans, set phase_sel=0, set scan_count=0, set busy=1, and enter RUN.
REQ-015 In IDLE, start=1 with n_phases=0 or n_scans=0 SHALL pulse cfg_err for one cycle on the next edge, remain in IDLE, and leave all other outputs unchanged.
REQ-016 The latched configuration SHALL be used for the entire acquisition; changes to n_phases or n_scans during RUN SHALL have no effect.
REQ-017 In RUN, a non-final scan_end SHALL, on the next edge, increment scan_count by 1 and advance phase_sel to phase_sel+1, wrapping to 0 when phase_sel+1 equals the latched n_phases.
REQ-018 In RUN, the final scan_end (scan_count+1 equal to the latched n_scans) SHALL, on the next edge, set scan_count=n_scans, set phase_sel=0, set busy=0, set done=1, and enter DONE.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE with done=0; start and scan_end received while in DONE SHALL be ignored.
REQ-020 scan_count SHALL hold its final value in IDLE until the next accepted start.
REQ-021 start received during RUN SHALL be ignored, and cfg_err SHALL NOT pulse.
REQ-022 scan_end received in IDLE SHALL be ignored.
REQ-023 abort received in RUN SHALL, on the next edge, enter IDLE with busy=0, phase_sel=0, done=0, and scan_count held at its current value.
REQ-024 When abort and scan_end are both high in the same cycle, abort SHALL take priority and scan_end SHALL be discarded.
REQ-025 When abort and start are both high in the same cycle in IDLE, start SHALL be ignored and no cfg_err SHALL be produced.
REQ-026 phase_sel SHALL never take the value 3, and SHALL never equal or exceed the latched n_phases while in RUN.
REQ-027 With n_phases=1, phase_sel SHALL remain 0 for the entire acquisition.
REQ-028 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-029 While rst_n=0 at a clk edge, the block SHALL enter IDLE with phase_sel=0, scan_count=0, busy=0, done=0, cfg_err=0, and the latched configuration cleared to 0.
REQ-030 Reset asserted mid-RUN SHALL override every other input in that cycle; done SHALL NOT pulse, and the first edge after rst_n returns high SHALL observe IDLE.

Verification
REQ-031 Normal run: n_phases=3, n_scans=7, start, then 7 scan_end pulses -> phase_sel sequence 0,1,2,0,1,2,0; done pulses once, one cycle after the 7th pulse; scan_count=7; phase_sel=0; busy=0.
REQ-032 Wrap at 2: n_phases=2, n_scans=4 -> phase_sel sequence 0,1,0,1, then 0 after done; start asserted mid-run is ignored.
REQ-033 Config error: start with n_scans=0 -> single-cycle cfg_err, busy stays 0; start with n_phases=0 -> same result.
REQ-034 Abort: n_phases=3, n_scans=10, three scan_end pulses, then abort together with a scan_end -> IDLE, scan_count=3, phase_sel=0, no done pulse.
REQ-035 Reset mid-run: rst_n=0 after two scans -> all outputs 0 on the next edge; a fresh start afterwards runs correctly from scan_count=0.
REQ-036 Boundary: n_scans=1, n_phases=1 -> exactly one scan_end produces done; n_scans=65535 -> scan_count reaches 65535 without overflow.
